ex_mem_buf: RTL

EX_MEM_BUF -- requirements
Module: ex_mem_buf

---
 rtl/ex_mem_buf.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ex_mem_buf.sv
// ex_mem_buf -- EX/MEM pipeline buffer implemented as a 2-entry in-order FIFO.
//
// Each entry holds {alu_out, zero, store_data, rd, ctrl}. The head entry is
// presented to the memory stage and also serves as the forwarding source for
// the ALU operand muxes.
//
// Optional feature (macro EXMEM_STALL_CNT_EN): when defined, adds output
// stall_cnt, a saturating count of cycles with mem_valid && !mem_ready.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   ex_valid/ex_ready   execute-stage handshake (ex_ready depends on state only)
//   ex_alu_out, ex_zero, ex_store_data, ex_rd, ex_ctrl   incoming payload
//                       (ex_ctrl = {reg_wr, mem_rd, mem_wr})
//   flush               synchronous kill of all stored and incoming entries
//   mem_valid/mem_ready memory-stage handshake for the head entry
//   mem_alu_out, mem_zero, mem_store_data, mem_rd, mem_ctrl   head payload
//   fwd_valid, fwd_rd, fwd_data   forwarding source taken from the head entry
//   stall_cnt           (EXMEM_STALL_CNT_EN only) stall cycle counter
module ex_mem_buf #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [XLEN-1:0]    ex_alu_out,
  input  logic               ex_zero,
  input  logic [XLEN-1:0]    ex_store_data,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic [2:0]         ex_ctrl,
  input  logic               flush,
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic [XLEN-1:0]    mem_alu_out,
  output logic               mem_zero,
  output logic [XLEN-1:0]    mem_store_data,
  output logic [RADDR_W-1:0] mem_rd,
  output logic [2:0]         mem_ctrl,
`ifdef EXMEM_STALL_CNT_EN
  output logic [31:0]        stall_cnt,
`endif
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]    fwd_data
);

  localparam int ENTRY_W = 2 * XLEN + RADDR_W + 4;

  logic [ENTRY_W-1:0] entry_reg [2];
  logic [ENTRY_W-1:0] ex_entry;
  logic [ENTRY_W-1:0] head_entry;

  logic [1:0] occ_reg, occ_next;
  logic       head_ptr_reg, head_ptr_next;
  logic       tail_ptr_reg, tail_ptr_next;
  logic       accept, pop;
  logic [1:0] wr_en;

  // Handshake flags come from registered occupancy only, so ex_ready has no
  // combinational path from mem_ready or ex_valid.
  assign ex_ready  = (occ_reg != 2'd2);
  assign mem_valid = (occ_reg != 2'd0);

  // flush wins over both accept and pop.
  assign accept = ex_valid && ex_ready && !flush;
  assign pop    = mem_valid && mem_ready && !flush;

  assign ex_entry = {ex_alu_out, ex_zero, ex_store_data, ex_rd, ex_ctrl};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_wr_en
      assign wr_en[gi] = accept && (tail_ptr_reg == 1'(gi));
    end
  endgenerate

  always_comb begin
    occ_next      = occ_reg;
    head_ptr_next = head_ptr_reg;
    tail_ptr_next = tail_ptr_reg;
    if (flush) begin
      occ_next      = 2'd0;
      head_ptr_next = 1'b0;
      tail_ptr_next = 1'b0;
    end else begin
      if (accept) tail_ptr_next = ~tail_ptr_reg;
      if (pop)    head_ptr_next = ~head_ptr_reg;
      unique case ({accept, pop})
        2'b10:   occ_next = occ_reg + 2'd1;
        2'b01:   occ_next = occ_reg - 2'd1;
        default: occ_next = occ_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg      <= 2'd0;
      head_ptr_reg <= 1'b0;
      tail_ptr_reg <= 1'b0;
    end else begin
      occ_reg      <= occ_next;
      head_ptr_reg <= head_ptr_next;
      tail_ptr_reg <= tail_ptr_next;
    end
  end

  // Payload storage; stale contents after a flush are harmless because
  // mem_valid/fwd_valid are gated by occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) entry_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en[i]) entry_reg[i] <= ex_entry;
      end
    end
  end

  assign head_entry = entry_reg[head_ptr_reg];
  assign {mem_alu_out, mem_zero, mem_store_data, mem_rd, mem_ctrl} = head_entry;

  // Forwarding: only a valid head that writes a non-zero register qualifies.
  assign fwd_valid = mem_valid && mem_ctrl[2] && (mem_rd != '0);
  assign fwd_rd    = mem_rd;
  assign fwd_data  = mem_alu_out;

`ifdef EXMEM_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  // Counts memory-side stall cycles; deliberately ignores flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (mem_valid && !mem_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
